// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and converter direction encodings.
// Functions work on a MAX_W-bit zero-extended value; callers size-cast the result back to their width.
package gray_pkg;

  localparam int MAX_W = 32;

  localparam logic CONV_B2G = 1'b0;
  localparam logic CONV_G2B = 1'b1;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits do not disturb the MSB-first prefix XOR.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] r;
    r[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_conv_pipe.sv
// Bidirectional bin<->Gray converter with a fixed STAGES-cycle latency.
// Conversion is done in the first stage; the remaining stages only delay the sample.
module gray_conv_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] conv_p0;
  logic [WIDTH-1:0] data_p [STAGES];
  logic [STAGES-1:0] vld_p;

  always_comb begin
    if (dir == CONV_G2B) begin
      conv_p0 = WIDTH'(gray2bin(MAX_W'(din)));
    end else begin
      conv_p0 = WIDTH'(bin2gray(MAX_W'(din)));
    end
  end

  // Stage 1 captures the converted sample; later stages shift it along.
  // Data registers load only on valid, so the output holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_p[s] <= '0;
      end
    end else begin
      vld_p[0] <= valid_in;
      if (valid_in) begin
        data_p[0] <= conv_p0;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s] <= vld_p[s-1];
        if (vld_p[s-1]) begin
          data_p[s] <= data_p[s-1];
        end
      end
    end
  end

  assign valid_out = vld_p[STAGES-1];
  assign dout      = data_p[STAGES-1];

endmodule

// File: rtl/gray_code_unit.sv
// Up/down Gray-code counter with synchronous load, plus an independent
// pipelined bin<->Gray converter. The two sections share only clk and rst_n.
module gray_code_unit
  import gray_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cnt_en,
  input  logic             cnt_dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic             wrap,
  input  logic             conv_valid_in,
  input  logic             conv_dir,
  input  logic [WIDTH-1:0] conv_in,
  output logic             conv_valid_out,
  output logic [WIDTH-1:0] conv_out
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] gray_r;
  logic             wrap_r;
  logic             wrap_nxt;

  // Binary is the real state; Gray is re-encoded from the next value so
  // both outputs change on the same edge.
  always_comb begin
    b_nxt    = b_q;
    wrap_nxt = 1'b0;
    if (load) begin
      b_nxt = WIDTH'(gray2bin(MAX_W'(load_gray)));
    end else if (cnt_en) begin
      if (cnt_dir == 1'b0) begin
        b_nxt    = b_q + WIDTH'(1);
        wrap_nxt = &b_q;
      end else begin
        b_nxt    = b_q - WIDTH'(1);
        wrap_nxt = (b_q == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q    <= '0;
      gray_r <= '0;
      wrap_r <= 1'b0;
    end else begin
      b_q    <= b_nxt;
      gray_r <= WIDTH'(bin2gray(MAX_W'(b_nxt)));
      wrap_r <= wrap_nxt;
    end
  end

  assign gray_q = gray_r;
  assign bin_q  = b_q;
  assign wrap   = wrap_r;

  gray_conv_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (conv_valid_in),
    .dir       (conv_dir),
    .din       (conv_in),
    .valid_out (conv_valid_out),
    .dout      (conv_out)
  );

endmodule
